// File: rtl/gauss_pkg.sv
// gauss_pkg
//   Shared definitions for the 3x3 Gaussian window producer.
//   - corner_e : window position code handed to the Gaussian computing block,
//                which uses it to pick the coefficient set matching the zero taps.
//   - state_e  : window generator FSM encodings (FILL / RUN / FLUSH).
//   - corner_of: maps the window's edge flags onto a corner_e code.
package gauss_pkg;

  typedef enum logic [3:0] {
    CT_IDLE   = 4'd0,  // no window presented
    CT_TL     = 4'd1,  // top-left corner
    CT_TR     = 4'd2,  // top-right corner
    CT_LEFT   = 4'd3,  // left column
    CT_RIGHT  = 4'd4,  // right column
    CT_BL     = 4'd5,  // bottom-left corner
    CT_BR     = 4'd6,  // bottom-right corner
    CT_BOTTOM = 4'd7,  // bottom row interior
    CT_FULL   = 4'd8   // interior and top row interior
  } corner_e;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Top row interior shares CT_FULL: its missing row is removed by zero taps alone.
  function automatic corner_e corner_of(input logic x_first, input logic x_last,
                                        input logic y_first, input logic y_last);
    corner_e ct;
    if (y_first) begin
      if (x_first)     ct = CT_TL;
      else if (x_last) ct = CT_TR;
      else             ct = CT_FULL;
    end else if (y_last) begin
      if (x_first)     ct = CT_BL;
      else if (x_last) ct = CT_BR;
      else             ct = CT_BOTTOM;
    end else begin
      if (x_first)     ct = CT_LEFT;
      else if (x_last) ct = CT_RIGHT;
      else             ct = CT_FULL;
    end
    return ct;
  endfunction

endpackage

// File: rtl/gauss_line_buf.sv
// gauss_line_buf
//   DEPTH-entry delay line built on a single-port RAM with read-before-write:
//   o_data always shows the entry at the pointer (written DEPTH enables ago);
//   on i_en that entry is overwritten with i_data and the pointer advances.
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (pointer only; RAM is don't-care)
//   i_en   in   advance the line by one entry
//   i_data in   DATA_WIDTH value entering the line
//   o_data out  DATA_WIDTH value leaving the line
module gauss_line_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_ptr;

  assign o_data = r_mem[r_ptr];

  // Circular pointer over the RAM entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      if (r_ptr == PTR_LAST) r_ptr <= '0;
      else                   r_ptr <= r_ptr + PW'(1);
    end
  end

  // RAM write; no reset so the array maps onto memory resources.
  always_ff @(posedge clk) begin
    if (i_en) r_mem[r_ptr] <= i_data;
  end

endmodule

// File: rtl/gauss_window_gen.sv
// gauss_window_gen
//   Producer side of the 3x3 Gaussian datapath. Buffers two raster lines and
//   emits one 3x3 window plus corner_type per pixel; out-of-frame taps are 0.
//   Tap naming lineR_dataC: line0 = row y+1, line2 = row y-1;
//   data0 = column x+1, data2 = column x-1.
// Ports
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  input handshake; in_data raster pixel
//   out_valid/out_ready output handshake
//   line0..2_data0..2  window taps (registered, held while stalled)
//   corner_type        gauss_pkg::corner_e code of the window, 0 when idle
//   out_eof            set with the window of pixel (W-1,H-1)
// Optional feature (macro GAUSS_WIN_SOF_EN)
//   Adds in_sof (start of frame, qualified by in_valid) and sticky sof_err.
//   in_sof away from (0,0) restarts the frame at that pixel; a missing in_sof
//   at (0,0) only flags the error.
module gauss_window_gen
  import gauss_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
`ifdef GAUSS_WIN_SOF_EN
  input  logic                  in_sof,
  output logic                  sof_err,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] line0_data0,
  output logic [DATA_WIDTH-1:0] line0_data1,
  output logic [DATA_WIDTH-1:0] line0_data2,
  output logic [DATA_WIDTH-1:0] line1_data0,
  output logic [DATA_WIDTH-1:0] line1_data1,
  output logic [DATA_WIDTH-1:0] line1_data2,
  output logic [DATA_WIDTH-1:0] line2_data0,
  output logic [DATA_WIDTH-1:0] line2_data1,
  output logic [DATA_WIDTH-1:0] line2_data2,
  output logic [3:0]            corner_type,
  output logic                  out_eof
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  state_e                r_state;
  corner_e               r_corner;
  logic                  r_out_valid;
  logic                  r_out_eof;
  logic [XW-1:0]         r_in_x;
  logic [YW-1:0]         r_in_y;
  logic [XW-1:0]         r_out_x;
  logic [YW-1:0]         r_out_y;
  logic [DATA_WIDTH-1:0] r_sh1 [3];     // last column pushed (unmasked)
  logic [DATA_WIDTH-1:0] r_sh2 [3];     // column before that (unmasked)
  logic [DATA_WIDTH-1:0] r_tap [3][3];  // [line][data], masked output window

  logic                  w_out_free;
  logic                  w_accept;
  logic                  w_flush_step;
  logic                  w_step;
  logic                  w_emit;
  logic                  w_restart;
  logic                  w_x_first;
  logic                  w_x_last;
  logic                  w_y_first;
  logic                  w_y_last;
  logic [2:0]            w_row_off;     // bit l set: line l lies outside the frame
  logic [DATA_WIDTH-1:0] w_lb1;
  logic [DATA_WIDTH-1:0] w_lb2;
  logic [DATA_WIDTH-1:0] w_col [3];     // column entering the window (col x+1)
  logic [DATA_WIDTH-1:0] w_tap [3][3];

  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = !rst && (r_state != ST_FLUSH) && w_out_free;
  assign w_accept   = in_valid && in_ready;
  // The eof window is the last flush step; after it only its transfer is awaited.
  assign w_flush_step = (r_state == ST_FLUSH) && w_out_free && !r_out_eof;
  // One step shifts one column through both line buffers and the tap registers.
  assign w_step = w_accept || w_flush_step;
  assign w_emit = w_step && (r_state != ST_FILL) && !w_restart;

`ifdef GAUSS_WIN_SOF_EN
  logic w_in_at_origin;
  logic r_sof_err;
  assign w_in_at_origin = (r_in_x == '0) && (r_in_y == '0);
  assign w_restart      = w_accept && in_sof && !w_in_at_origin;
  assign sof_err        = r_sof_err;

  // Sticky frame-sync error: in_sof must coincide exactly with pixel (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sof_err <= 1'b0;
    end else if (w_accept && (in_sof != w_in_at_origin)) begin
      r_sof_err <= 1'b1;
    end
  end
`else
  assign w_restart = 1'b0;
`endif

  assign w_x_first = (r_out_x == '0);
  assign w_x_last  = (r_out_x == X_LAST);
  assign w_y_first = (r_out_y == '0);
  assign w_y_last  = (r_out_y == Y_LAST);
  assign w_row_off = {w_y_first, 1'b0, w_y_last};

  // Row y+1 has no source during flush; it is always masked there anyway.
  assign w_col[0] = (r_state == ST_FLUSH) ? '0 : in_data;
  assign w_col[1] = w_lb1;
  assign w_col[2] = w_lb2;

  gauss_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_line_y (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_step),
    .i_data (w_col[0]),
    .o_data (w_lb1)
  );

  gauss_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_line_ym1 (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_step),
    .i_data (w_lb1),
    .o_data (w_lb2)
  );

  // Next window: new column as data0, shifted columns as data1/data2, edge taps zeroed.
  always_comb begin
    for (int l = 0; l < 3; l++) begin
      w_tap[l][0] = (w_row_off[l] || w_x_last)  ? '0 : w_col[l];
      w_tap[l][1] =  w_row_off[l]               ? '0 : r_sh1[l];
      w_tap[l][2] = (w_row_off[l] || w_x_first) ? '0 : r_sh2[l];
    end
  end

  // Unmasked column history; kept apart from r_tap so masking never corrupts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh1 <= '{default: '0};
      r_sh2 <= '{default: '0};
    end else if (w_step) begin
      r_sh1 <= w_col;
      r_sh2 <= r_sh1;
    end
  end

  // Control FSM, raster counters and registered window outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FILL;
      r_corner    <= CT_IDLE;
      r_out_valid <= 1'b0;
      r_out_eof   <= 1'b0;
      r_in_x      <= '0;
      r_in_y      <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_tap       <= '{default: '0};
    end else begin
      // Position of the next input pixel; a restart makes this pixel (0,0).
      if (w_restart) begin
        r_in_x <= XW'(1);
        r_in_y <= '0;
      end else if (w_accept) begin
        if (r_in_x == X_LAST) begin
          r_in_x <= '0;
          r_in_y <= (r_in_y == Y_LAST) ? '0 : r_in_y + YW'(1);
        end else begin
          r_in_x <= r_in_x + XW'(1);
        end
      end

      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_tap       <= w_tap;
        r_corner    <= corner_of(w_x_first, w_x_last, w_y_first, w_y_last);
        r_out_eof   <= w_x_last && w_y_last;
        if (w_x_last) begin
          r_out_x <= '0;
          r_out_y <= w_y_last ? '0 : r_out_y + YW'(1);
        end else begin
          r_out_x <= r_out_x + XW'(1);
        end
      end else if (w_restart) begin
        r_out_valid <= 1'b0;
        r_corner    <= CT_IDLE;
        r_out_eof   <= 1'b0;
        r_out_x     <= '0;
        r_out_y     <= '0;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        r_corner    <= CT_IDLE;
        r_out_eof   <= 1'b0;
      end

      if (w_restart) begin
        r_state <= ST_FILL;
      end else begin
        case (r_state)
          // Pixel (0,1) is the (W+1)th pixel: the next one completes window (0,0).
          ST_FILL:  if (w_accept && (r_in_x == '0) && (r_in_y == YW'(1))) r_state <= ST_RUN;
          ST_RUN:   if (w_accept && (r_in_x == X_LAST) && (r_in_y == Y_LAST)) r_state <= ST_FLUSH;
          ST_FLUSH: if (r_out_valid && out_ready && r_out_eof) r_state <= ST_FILL;
          default:  r_state <= ST_FILL;
        endcase
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign corner_type = r_corner;
  assign out_eof     = r_out_eof;
  assign line0_data0 = r_tap[0][0];
  assign line0_data1 = r_tap[0][1];
  assign line0_data2 = r_tap[0][2];
  assign line1_data0 = r_tap[1][0];
  assign line1_data1 = r_tap[1][1];
  assign line1_data2 = r_tap[1][2];
  assign line2_data0 = r_tap[2][0];
  assign line2_data1 = r_tap[2][1];
  assign line2_data2 = r_tap[2][2];

endmodule

// File: tb/tb_gauss_window_gen.sv
// tb_gauss_window_gen
//   Scoreboard bench for gauss_window_gen with a 4x3 image, pixel = 4*y+x+1+offset.
//   Stimulus pushes the expected windows of each frame into a queue; an
//   independent monitor pops and compares on every output transfer, and also
//   checks stall stability, in_ready during stall and corner_type while idle.
//   Builds with or without GAUSS_WIN_SOF_EN.
module tb_gauss_window_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] line0_data0, line0_data1, line0_data2;
  logic [DW-1:0] line1_data0, line1_data1, line1_data2;
  logic [DW-1:0] line2_data0, line2_data1, line2_data2;
  logic [3:0]    corner_type;
  logic          out_eof;
`ifdef GAUSS_WIN_SOF_EN
  logic          in_sof;
  logic          sof_err;
`endif

  logic [71:0] w_taps;
  assign w_taps = {line0_data0, line0_data1, line0_data2,
                   line1_data0, line1_data1, line1_data2,
                   line2_data0, line2_data1, line2_data2};

  gauss_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
`ifdef GAUSS_WIN_SOF_EN
    .in_sof      (in_sof),
    .sof_err     (sof_err),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .line0_data0 (line0_data0),
    .line0_data1 (line0_data1),
    .line0_data2 (line0_data2),
    .line1_data0 (line1_data0),
    .line1_data1 (line1_data1),
    .line1_data2 (line1_data2),
    .line2_data0 (line2_data0),
    .line2_data1 (line2_data1),
    .line2_data2 (line2_data2),
    .corner_type (corner_type),
    .out_eof     (out_eof)
  );

  typedef struct packed {
    logic [71:0] taps;
    logic [3:0]  ct;
    logic        eof;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   bp_mode = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pixel value, 0 outside the frame.
  function automatic logic [7:0] pix(input int x, input int y, input int off);
    if (x < 0 || x >= W || y < 0 || y >= H) return 8'd0;
    return 8'(4 * y + x + 1 + off);
  endfunction

  function automatic logic [3:0] exp_ct(input int x, input int y);
    logic [3:0] r;
    if (y == 0)          r = (x == 0) ? 4'd1 : ((x == W - 1) ? 4'd2 : 4'd8);
    else if (y == H - 1) r = (x == 0) ? 4'd5 : ((x == W - 1) ? 4'd6 : 4'd7);
    else                 r = (x == 0) ? 4'd3 : ((x == W - 1) ? 4'd4 : 4'd8);
    return r;
  endfunction

  // lineL_dataD = pixel at column x+1-D, row y+1-L.
  function automatic exp_t mk_exp(input int x, input int y, input int off);
    exp_t e;
    e.taps = 72'd0;
    for (int l = 0; l < 3; l++)
      for (int d = 0; d < 3; d++)
        e.taps[71 - 8 * (3 * l + d) -: 8] = pix(x + 1 - d, y + 1 - l, off);
    e.ct  = exp_ct(x, y);
    e.eof = (x == W - 1) && (y == H - 1);
    return e;
  endfunction

  task automatic push_frame(input int off);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        q.push_back(mk_exp(x, y, off));
  endtask

  // Present pixels first..first+count-1; called and returns at posedge+#1.
  task automatic send_pixels(input int off, input int first, input int count, input bit sof_first);
    for (int i = first; i < first + count; i++) begin
      bit acc;
      int waited;
      in_valid = 1'b1;
      in_data  = pix(i % W, i / W, off);
`ifdef GAUSS_WIN_SOF_EN
      in_sof   = sof_first && (i == first);
`endif
      acc    = 1'b0;
      waited = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        waited++;
        if (!acc && waited > 60) begin
          n_tests++;
          n_fail++;
          $display("FAIL in_accept: pixel %0d (sof=%0b) in_ready=%0b, required accept within 60 cycles",
                   i, sof_first, in_ready);
          return;
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d windows still expected, required 0", name, q.size());
    end
  endtask

  task automatic check_reset(input string name);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_eof !== 1'b0 ||
        corner_type !== 4'd0 || w_taps !== 72'd0) begin
      n_fail++;
      $display("FAIL %s: valid=%b ready=%b eof=%b ct=%0d taps=%h, required all 0",
               name, out_valid, in_ready, out_eof, corner_type, w_taps);
    end
  endtask

  // Output-ready driver: constant 1, or high one cycle in three under backpressure.
  initial begin
    int cnt;
    cnt = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      out_ready = bp_mode ? (cnt % 3 == 0) : 1'b1;
    end
  end

  // Monitor: scoreboard pop on transfer, stall stability, idle corner code.
  initial begin
    exp_t got;
    exp_t e;
    exp_t held;
    bit   prev_stall;
    int   win;
    prev_stall = 1'b0;
    win = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        got = {w_taps, corner_type, out_eof};
        if (prev_stall) begin
          n_tests++;
          if (out_valid !== 1'b1 || got !== held) begin
            n_fail++;
            $display("FAIL stall_hold: valid=%b out=%h, required valid=1 out=%h", out_valid, got, held);
          end
        end
        if (out_valid && !out_ready) begin
          n_tests++;
          if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_in_ready: in_ready=%b, required 0", in_ready);
          end
        end
        if (!out_valid) begin
          n_tests++;
          if (corner_type !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_corner: corner_type=%0d, required 0", corner_type);
          end
        end
        if (out_valid && out_ready) begin
          n_tests++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL window[%0d]: unexpected window taps=%h ct=%0d, required none", win, w_taps, corner_type);
          end else begin
            e = q.pop_front();
            if (got !== e) begin
              n_fail++;
              $display("FAIL window[%0d]: taps=%h ct=%0d eof=%b, required taps=%h ct=%0d eof=%b",
                       win, got.taps, got.ct, got.eof, e.taps, e.ct, e.eof);
            end
          end
          win++;
        end
        prev_stall = out_valid && !out_ready;
        held = got;
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef GAUSS_WIN_SOF_EN
    in_sof   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full frame, no backpressure.
    push_frame(0);
    send_pixels(0, 0, W * H, 1'b1);
    in_valid = 1'b0;
    drain("frame_plain");

    // Same frame shape under 1-of-3 output readiness.
    bp_mode = 1'b1;
    push_frame(30);
    send_pixels(30, 0, W * H, 1'b1);
    in_valid = 1'b0;
    drain("frame_backpressure");
    bp_mode = 1'b0;

    // Two frames with in_valid held high throughout.
    push_frame(60);
    push_frame(100);
    send_pixels(60, 0, W * H, 1'b1);
    send_pixels(100, 0, W * H, 1'b1);
    in_valid = 1'b0;
    drain("frames_back_to_back");

    // Six pixels (window (0,0) emerges), then reset mid-frame and a fresh frame.
    q.push_back(mk_exp(0, 0, 150));
    send_pixels(150, 0, 6, 1'b1);
    in_valid = 1'b0;
    drain("partial_frame");
    rst = 1'b1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check_reset("mid_reset");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_frame(170);
    send_pixels(170, 0, W * H, 1'b1);
    in_valid = 1'b0;
    drain("frame_after_reset");

`ifdef GAUSS_WIN_SOF_EN
    n_tests++;
    if (sof_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sof_err_clean: sof_err=%b, required 0", sof_err);
    end
    // Five pixels of an abandoned frame, then in_sof on the sixth pixel.
    send_pixels(0, 0, 5, 1'b1);
    push_frame(200);
    send_pixels(200, 0, W * H, 1'b1);
    in_valid = 1'b0;
    drain("frame_after_sof_restart");
    n_tests++;
    if (sof_err !== 1'b1) begin
      n_fail++;
      $display("FAIL sof_err_set: sof_err=%b, required 1", sof_err);
    end
`endif

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: %0d windows outstanding, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
